// File: rtl/alu_seq.sv
// Registered ALU with a valid/ready handshake on both sides. Single-cycle ops
// finish one edge after accept; mul/div iterate one bit per cycle.
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] r,
   output logic [WIDTH-1:0] r_hi,
   output logic             zero,
   output logic             carry,
   output logic             negative,
   output logic             overflow
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q;
   logic             ov_q;
   logic [SHW-1:0]   cnt_q;
   logic [1:0]       mop_q;
   logic [WIDTH-1:0] hi_q, lo_q, md_q, a_q;
   logic             nres_q, nrem_q, dz_q, dovf_q;
   logic [WIDTH-1:0] r_q, rhi_q;
   logic             z_q, c_q, n_q, v_q;

   logic accept, is_md;
   assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign is_md     = op[4] & (op[3:2] == 2'b00);
   assign out_valid = ov_q;
   assign r         = r_q;
   assign r_hi      = rhi_q;
   assign zero      = z_q;
   assign carry     = c_q;
   assign negative  = n_q;
   assign overflow  = v_q;

   // Single-cycle datapath, evaluated straight from the request
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] dif, sr;
   logic [SHW-1:0]   sh, shm1, lidx;
   logic             lt_u, lt_s, sz, sc, sn, sv;

   always_comb begin
      sum  = {1'b0, a} + {1'b0, b};
      dif  = a - b;
      sh   = a[SHW-1:0];
      shm1 = sh - SHW'(1);
      lidx = '0 - sh;
      lt_u = a < b;
      lt_s = $signed(a) < $signed(b);
      sr = '0;
      sc = 1'b0;
      sv = 1'b0;
      case (op)
         5'b00000: begin sr = sum[WIDTH-1:0]; sc = sum[WIDTH]; end
         5'b00001: begin sr = dif; sc = lt_u; end
         5'b00010: begin
            sr = sum[WIDTH-1:0];
            sv = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
         end
         5'b00011: begin
            sr = dif;
            sv = (a[WIDTH-1] != b[WIDTH-1]) & (dif[WIDTH-1] != a[WIDTH-1]);
         end
         5'b00100: sr = a & b;
         5'b00101: sr = a | b;
         5'b00110: sr = a ^ b;
         5'b00111: sr = ~(a | b);
         5'b01000, 5'b01001: sr = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         5'b01010: begin sr = {{(WIDTH-1){1'b0}}, lt_u}; sc = lt_u; end
         5'b01011: sr = {{(WIDTH-1){1'b0}}, lt_s};
         5'b01100: begin sr = $signed(b) >>> sh; sc = (sh != '0) & b[shm1]; end
         5'b01101: begin sr = b >> sh; sc = (sh != '0) & b[shm1]; end
         5'b01110, 5'b01111: begin sr = b << sh; sc = (sh != '0) & b[lidx]; end
         default: ;
      endcase
      sz = (sr == '0);
      sn = sr[WIDTH-1];
      if (op == 5'b01010) begin sz = (a == b); sn = 1'b0; end
      if (op == 5'b01011) begin sz = (a == b); sn = sr[0]; end
      if (op[4]) begin sz = 1'b0; sn = 1'b0; end
   end

   // Operand magnitudes; signs are reapplied on the final iteration
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] ma, mb;
   assign a_neg = op[0] & a[WIDTH-1];
   assign b_neg = op[0] & b[WIDTH-1];
   assign ma    = a_neg ? -a : a;
   assign mb    = b_neg ? -b : b;

   logic [WIDTH:0]     msum;
   logic               ge;
   logic [WIDTH-1:0]   nhi, nlo, q, rm, fr, frh;
   logic [2*WIDTH-1:0] prod;
   logic               fz, fn, fv;

   always_comb begin
      msum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : '0);
      ge   = {hi_q, lo_q[WIDTH-1]} >= {1'b0, md_q};
      if (!mop_q[1]) begin
         nhi = msum[WIDTH:1];
         nlo = {msum[0], lo_q[WIDTH-1:1]};
      end else if (ge) begin
         nhi = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} - md_q;
         nlo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
         nhi = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
         nlo = {lo_q[WIDTH-2:0], 1'b0};
      end
      prod = nres_q ? -{nhi, nlo} : {nhi, nlo};
      q    = nres_q ? -nlo : nlo;
      rm   = nrem_q ? -nhi : nhi;
      fv   = 1'b0;
      if (dz_q) begin
         q = '1; rm = a_q; fv = 1'b1;
      end else if (dovf_q) begin
         q = MIN; rm = '0; fv = 1'b1;
      end
      if (!mop_q[1]) begin
         fr  = prod[WIDTH-1:0];
         frh = prod[2*WIDTH-1:WIDTH];
         fz  = (prod == '0);
         fn  = mop_q[0] & prod[2*WIDTH-1];
         fv  = 1'b0;
      end else begin
         fr  = q;
         frh = rm;
         fz  = (q == '0);
         fn  = mop_q[0] & q[WIDTH-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ov_q    <= 1'b0;
         cnt_q   <= '0;
         mop_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         md_q    <= '0;
         a_q     <= '0;
         nres_q  <= 1'b0;
         nrem_q  <= 1'b0;
         dz_q    <= 1'b0;
         dovf_q  <= 1'b0;
         r_q     <= '0;
         rhi_q   <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         n_q     <= 1'b0;
         v_q     <= 1'b0;
      end else if (accept) begin
         cnt_q  <= '0;
         mop_q  <= op[1:0];
         hi_q   <= '0;
         lo_q   <= ma;
         md_q   <= mb;
         a_q    <= a;
         nres_q <= a_neg ^ b_neg;
         nrem_q <= a_neg;
         dz_q   <= (b == '0);
         dovf_q <= op[0] & (a == MIN) & (&b);
         if (is_md) begin
            state_q <= BUSY;
            ov_q    <= 1'b0;
         end else begin
            state_q <= DONE;
            ov_q    <= 1'b1;
            r_q     <= sr;
            rhi_q   <= '0;
            z_q     <= sz;
            c_q     <= sc;
            n_q     <= sn;
            v_q     <= sv;
         end
      end else if (state_q == DONE && out_ready) begin
         state_q <= IDLE;
         ov_q    <= 1'b0;
      end else if (state_q == BUSY) begin
         cnt_q <= cnt_q + SHW'(1);
         hi_q  <= nhi;
         lo_q  <= nlo;
         if (cnt_q == LAST) begin
            state_q <= DONE;
            ov_q    <= 1'b1;
            r_q     <= fr;
            rhi_q   <= frh;
            z_q     <= fz;
            c_q     <= 1'b0;
            n_q     <= fn;
            v_q     <= fv;
         end
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Directed and random checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
   localparam int W = 32;

   logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [4:0]    op = '0;
   logic [W-1:0]  a = '0, b = '0;
   logic          in_ready, out_valid, zero, carry, negative, overflow;
   logic [W-1:0]  r, r_hi;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] r;
      logic [31:0] rh;
      logic z, c, n, v;
   } res_t;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .r(r), .r_hi(r_hi), .zero(zero), .carry(carry), .negative(negative),
      .overflow(overflow)
   );

   function automatic res_t model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
      res_t e;
      longint sx, sy, ux, uy, t;
      logic [63:0] p;
      int sh;
      e  = '0;
      sx = $signed(x);
      sy = $signed(y);
      ux = longint'({32'b0, x});
      uy = longint'({32'b0, y});
      sh = int'(x[4:0]);
      case (o)
         5'd0: begin p = ux + uy; e.r = p[31:0]; e.c = p[32]; end
         5'd1: begin e.r = x - y; e.c = (ux < uy); end
         5'd2: begin t = sx + sy; e.r = t[31:0]; e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
         5'd3: begin t = sx - sy; e.r = t[31:0]; e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
         5'd4: e.r = x & y;
         5'd5: e.r = x | y;
         5'd6: e.r = x ^ y;
         5'd7: e.r = ~(x | y);
         5'd8, 5'd9: e.r = {y[15:0], 16'h0};
         5'd10: begin e.r = (ux < uy) ? 32'd1 : 32'd0; e.c = e.r[0]; end
         5'd11: e.r = (sx < sy) ? 32'd1 : 32'd0;
         5'd12: begin e.r = $signed(y) >>> sh; e.c = (sh == 0) ? 1'b0 : y[sh-1]; end
         5'd13: begin e.r = y >> sh; e.c = (sh == 0) ? 1'b0 : y[sh-1]; end
         5'd14, 5'd15: begin p = {32'b0, y} << sh; e.r = p[31:0]; e.c = p[32]; end
         5'd16, 5'd17: begin
            p = (o == 5'd17) ? 64'(sx * sy) : 64'(ux * uy);
            e.r = p[31:0]; e.rh = p[63:32];
         end
         5'd18, 5'd19: begin
            if (y == 0) begin
               e.r = 32'hFFFFFFFF; e.rh = x; e.v = 1'b1;
            end else if (o == 5'd19 && x == 32'h80000000 && y == 32'hFFFFFFFF) begin
               e.r = 32'h80000000; e.rh = 0; e.v = 1'b1;
            end else if (o == 5'd18) begin
               t = ux / uy; e.r = t[31:0]; t = ux % uy; e.rh = t[31:0];
            end else begin
               t = sx / sy; e.r = t[31:0]; t = sx % sy; e.rh = t[31:0];
            end
         end
         default: ;
      endcase
      if (o <= 5'd9 || (o >= 5'd12 && o <= 5'd15)) begin e.z = (e.r == 0); e.n = e.r[31]; end
      if (o == 5'd10 || o == 5'd11) e.z = (x == y);
      if (o == 5'd11) e.n = e.r[0];
      if (o == 5'd16 || o == 5'd17) begin e.z = ({e.rh, e.r} == 0); e.n = (o == 5'd17) && e.rh[31]; end
      if (o == 5'd18 || o == 5'd19) begin e.z = (e.r == 0); e.n = (o == 5'd19) && e.r[31]; end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input res_t e);
      chk({tag, ".r"}, 64'(r), 64'(e.r));
      chk({tag, ".r_hi"}, 64'(r_hi), 64'(e.rh));
      chk({tag, ".zcnv"}, 64'({zero, carry, negative, overflow}), 64'({e.z, e.c, e.n, e.v}));
   endtask

   // Issues one request with out_ready high and checks latency and result.
   task automatic run(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
      int lat, k;
      bit rdy_busy, md;
      md = o[4] && (o[3:2] == 2'b00);
      @(negedge clk);
      op = o; a = x; b = y; in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 100) begin @(negedge clk); k++; end
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 1;
      rdy_busy = 1'b0;
      while (!out_valid && lat < 100) begin
         rdy_busy |= in_ready;
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, ".lat"}, 64'(lat), md ? 64'd33 : 64'd1);
      if (md) chk({tag, ".busy_rdy"}, 64'(rdy_busy), 64'd0);
      chk_out(tag, model(o, x, y));
   endtask

   function automatic logic [31:0] rval();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      res_t e;
      logic [4:0] ro;
      logic [31:0] rx, ry;

      repeat (2) @(posedge clk);
      #1;
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.in_ready", 64'(in_ready), 64'd1);
      chk_out("rst", '0);
      @(negedge clk);
      rst_n = 1'b1;

      run(5'd0, 32'hFFFFFFFF, 32'h1, "addu_wrap");
      run(5'd2, 32'h7FFFFFFF, 32'h1, "add_ovf");
      run(5'd11, 32'hFFFFFFFF, 32'h1, "slt");
      run(5'd10, 32'hFFFFFFFF, 32'h1, "sltu");
      run(5'd11, 32'd5, 32'd5, "slt_eq");
      chk("slt_eq.zero", 64'(zero), 64'd1);
      run(5'd12, 32'd4, 32'h80000000, "sra");
      chk("sra.r_const", 64'(r), 64'hF8000000);
      run(5'd14, 32'd1, 32'h80000001, "sll");
      chk("sll.carry_const", 64'(carry), 64'd1);
      run(5'd13, 32'd0, 32'hA5A5A5A5, "srl_sh0");
      run(5'd17, 32'hFFFFFFFD, 32'd5, "mul_neg");
      chk("mul_neg.r_const", 64'({r_hi, r}), 64'hFFFFFFFF_FFFFFFF1);
      run(5'd19, 32'd7, 32'hFFFFFFFE, "div_neg");
      chk("div_neg.r_const", 64'({r_hi, r}), 64'h00000001_FFFFFFFD);
      run(5'd18, 32'h12345678, 32'h0, "divu_zero");
      run(5'd19, 32'h80000000, 32'hFFFFFFFF, "div_min");
      run(5'd20, 32'h12345678, 32'h9, "reserved");

      // Backpressure: drain to idle, then stall an ADD result for 5 cycles
      repeat (2) @(negedge clk);
      out_ready = 1'b0;
      op = 5'd2; a = 32'h40000000; b = 32'h40000000; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      e = model(5'd2, 32'h40000000, 32'h40000000);
      chk("bp.valid0", 64'(out_valid), 64'd1);
      chk_out("bp.first", e);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp.valid_hold", 64'(out_valid), 64'd1);
         chk("bp.in_ready", 64'(in_ready), 64'd0);
         chk_out("bp.hold", e);
      end
      @(negedge clk);
      out_ready = 1'b1;
      op = 5'd3; a = 32'd100; b = 32'd1; in_valid = 1'b1;
      #1 chk("bp.ready_release", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("bp.next_valid", 64'(out_valid), 64'd1);
      chk_out("bp.next", model(5'd3, 32'd100, 32'd1));

      // Reset in the middle of a multiply
      @(negedge clk);
      op = 5'd17; a = 32'd1234; b = 32'd5678; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst.out_valid", 64'(out_valid), 64'd0);
      chk("midrst.in_ready", 64'(in_ready), 64'd1);
      chk_out("midrst", '0);
      @(negedge clk);
      rst_n = 1'b1;
      run(5'd16, 32'hDEADBEEF, 32'h01234567, "after_rst");

      for (int i = 0; i < 80; i++) begin
         ro = 5'($urandom_range(0, 31));
         rx = rval();
         ry = rval();
         run(ro, rx, ry, $sformatf("rand%0d_op%0d", i, ro));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised-width successor of the CPU's combinational ALU. Keeps the 4-bit ALU op set and adds a 5th op bit for iterative multiply/divide.
- Sits between the decode/operand-fetch stage and writeback.
- Uses a valid/ready handshake on both input and output, so the pipeline can stall while a multi-cycle mul/div is in flight.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8. Local SHW = log2(WIDTH).

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept this cycle
- op  in  5  operation select (encoding below)
- a  in  WIDTH  operand A; shift amount for shifts = a[SHW-1:0]
- b  in  WIDTH  operand B
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer takes result
- r  out  WIDTH  result; product low half; quotient
- r_hi  out  WIDTH  product high half; remainder; 0 for single-cycle ops
- zero, carry, negative, overflow  out  1 each  flags

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0; r, r_hi and all flags = 0; iteration counter = 0. Reset asserted mid-BUSY aborts the op; no result is produced.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready; operands and op are captured on that edge.
- FSM:
  - IDLE --accept single-cycle op--> DONE
  - IDLE --accept mul/div--> BUSY
  - BUSY: counter counts 0..WIDTH-1; on its last cycle the result is registered --> DONE
  - DONE: out_valid=1. On out_ready: accept-in-same-cycle goes to DONE/BUSY per the new op; otherwise --> IDLE.
- Outputs hold stable while out_valid & !out_ready.
- Latency:
  - Single-cycle op: out_valid on the edge after accept. Back-to-back ops give 1 result per cycle with out_ready held high.
  - Mul/div: out_valid WIDTH+1 edges after accept.
- Single-cycle ops (op[4]=0). Any flag not listed is 0.
  - 00000 ADDU: r=a+b; carry = bit WIDTH of the (WIDTH+1)-bit unsigned sum.
  - 00001 SUBU: r=a-b; carry = 1 iff a<b unsigned (borrow).
  - 00010 ADD: r=a+b; overflow = signs of a and b equal and r sign differs.
  - 00011 SUB: r=a-b; overflow = signs of a and b differ and r sign != a sign.
  - 00100 AND, 00101 OR, 00110 XOR, 00111 NOR.
  - 0100x LUI: r = {b[WIDTH/2-1:0], WIDTH/2 zeros}.
  - 01010 SLTU: r = (a<b unsigned); carry = r[0].
  - 01011 SLT: r = (a<b signed); negative = r[0].
  - 01100 SRA: r = b>>>sh (arithmetic).
  - 01101 SRL: r = b>>sh (logical).
  - 0111x SLL: r = b<<sh.
  - Shift carry = last bit shifted out (SRA/SRL: b[sh-1]; SLL: b[WIDTH-sh]); carry=0 when sh==0.
  - zero = (r==0), except SLT/SLTU, where zero = (a==b).
  - negative = r[WIDTH-1], except SLTU (0) and SLT (as above).
- Multi-cycle ops (op[4]=1):
  - 10000 MULU, 10001 MUL: shift-add on magnitudes, 1 bit/cycle. Signed sign-fixup on the final cycle. {r_hi,r} = full 2*WIDTH product.
  - 10010 DIVU, 10011 DIV: restoring division, 1 bit/cycle. r=quotient, r_hi=remainder. Signed: quotient truncates toward zero; remainder takes the sign of a.
  - Divide by zero: r = all ones, r_hi = a, overflow=1.
  - DIV of MIN by -1: r = MIN, r_hi = 0, overflow=1.
  - Mul flags: zero = ({r_hi,r}==0); negative = r_hi[WIDTH-1] for MUL, 0 for MULU; carry=0; overflow=0.
  - Div flags: zero = (r==0); negative = r[WIDTH-1] for DIV only.
- Reserved ops (101xx, 11xxx): 1-cycle latency; r=0, r_hi=0, all flags 0.
- in_valid while busy: ignored (in_ready=0); the upstream must hold the request.

Test Plan:
- WIDTH=32. ADDU a=FFFFFFFF b=1 -> r=0, carry=1, zero=1, out_valid on the next edge. ADD a=7FFFFFFF b=1 -> r=80000000, overflow=1, negative=1.
- SLT a=FFFFFFFF b=1 -> r=1, negative=1. SLTU with the same operands -> r=0, carry=0. SLT a=b=5 -> zero=1.
- SRA b=80000000 a=4 -> r=F8000000, carry=0. SLL b=80000001 a=1 -> r=2, carry=1. SRL with sh=0 -> r=b, carry=0.
- MUL a=-3 b=5 -> r_hi=FFFFFFFF, r=FFFFFFF1, negative=1. out_valid exactly 33 edges after accept; in_ready=0 throughout BUSY.
- DIV a=7 b=-2 -> r=FFFFFFFD, r_hi=1. DIVU b=0 -> r=FFFFFFFF, r_hi=a, overflow=1. DIV 80000000 by FFFFFFFF -> r=80000000, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD -> r and flags stable. Then out_ready=1 with a new in_valid -> accepted the same cycle. rst_n low mid-MUL -> out_valid=0, outputs 0 asynchronously; the next op runs normally.
